// File: rtl/jtframe_layer_mixer_if.sv
// Pixel, priority, palette and colour-output signals of jtframe_layer_mixer.
// master drives layers/config and receives colour; slave is the mixer side.
interface jtframe_layer_mixer_if #(
  parameter int LAYERS = 4,
  parameter int PXLW   = 8,
  parameter int CW     = 4,
  parameter int IDXW   = 3
);
  logic                     cen;
  logic                     lhbl;
  logic                     lvbl;
  logic [LAYERS*PXLW-1:0]   layer_pxl;
  logic [LAYERS-1:0]        layer_en;
  logic [LAYERS*IDXW-1:0]   prio_din;
  logic                     prio_we;
  logic [3*CW-1:0]          bg_color;
  logic [IDXW+PXLW-1:0]     pal_addr;
  logic [3*CW-1:0]          pal_din;
  logic                     pal_we;
  logic                     pause;
  logic [CW-1:0]            red;
  logic [CW-1:0]            green;
  logic [CW-1:0]            blue;
  logic                     lhbl_dly;
  logic                     lvbl_dly;

  modport master (
    output cen, lhbl, lvbl, layer_pxl, layer_en, prio_din, prio_we,
           bg_color, pal_addr, pal_din, pal_we, pause,
    input  red, green, blue, lhbl_dly, lvbl_dly
  );

  modport slave (
    input  cen, lhbl, lvbl, layer_pxl, layer_en, prio_din, prio_we,
           bg_color, pal_addr, pal_din, pal_we, pause,
    output red, green, blue, lhbl_dly, lvbl_dly
  );
endinterface

// File: rtl/jtframe_layer_mixer.sv
// N-layer priority mixer with double-buffered priority order and palette RAM, 3 cen latency.
// Optional JTFRAME_MIX_DIM_EN: halve every channel while pause is high.
module jtframe_layer_mixer #(
  parameter int LAYERS = 4,
  parameter int PXLW   = 8,
  parameter int CW     = 4,
  parameter int IDXW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtframe_layer_mixer_if.slave bus
);
  localparam int NSLOT = 2**IDXW;
  localparam int AW    = IDXW + PXLW;
  localparam int DW    = 3 * CW;

  if (NSLOT < LAYERS) begin : g_bad_idxw
    $error("IDXW too narrow for LAYERS");
  end

  function automatic logic [LAYERS*IDXW-1:0] prio_identity();
    logic [LAYERS*IDXW-1:0] v;
    v = '0;
    for (int s = 0; s < LAYERS; s++) v[s*IDXW +: IDXW] = IDXW'(s);
    return v;
  endfunction

  localparam logic [LAYERS*IDXW-1:0] PRIO_ID = prio_identity();

  logic [LAYERS*IDXW-1:0] prio_pend, prio_act;
  logic                   lvbl_last;
  logic [PXLW-1:0]        s1_pxl [LAYERS];
  logic [LAYERS-1:0]      s1_opq;
  logic                   s1_hb, s1_vb;
  logic [AW-1:0]          s2_addr;
  logic                   s2_bd, s2_hb, s2_vb;
  logic [CW-1:0]          red_q, green_q, blue_q;
  logic                   hb_q, vb_q;
  logic [DW-1:0]          mem [2**AW];

  logic [PXLW-1:0]        pxl_ext [NSLOT];
  logic [NSLOT-1:0]       opq_ext;
  logic [IDXW-1:0]        entry, win;
  logic                   found;
  logic [DW-1:0]          pix;
  logic [CW-1:0]          r_o, g_o, b_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_pend <= PRIO_ID;
    else if (bus.prio_we) prio_pend <= bus.prio_din;
  end

  always_ff @(posedge clk) begin
    if (bus.pal_we) mem[bus.pal_addr] <= bus.pal_din;
  end

  // Unused slots read as transparent, so out-of-range entries never win.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) pxl_ext[i] = '0;
    for (int i = 0; i < LAYERS; i++) pxl_ext[i] = s1_pxl[i];
    opq_ext = NSLOT'(s1_opq);
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    entry = '0;
    for (int s = 0; s < LAYERS; s++) begin
      entry = prio_act[s*IDXW +: IDXW];
      if (!found && opq_ext[entry]) begin
        found = 1'b1;
        win   = entry;
      end
    end
  end

  always_comb begin
    pix = s2_bd ? bus.bg_color : mem[s2_addr];
`ifdef JTFRAME_MIX_DIM_EN
    r_o = bus.pause ? (pix[DW-1 -: CW] >> 1)   : pix[DW-1 -: CW];
    g_o = bus.pause ? (pix[2*CW-1 -: CW] >> 1) : pix[2*CW-1 -: CW];
    b_o = bus.pause ? (pix[CW-1:0] >> 1)       : pix[CW-1:0];
`else
    r_o = pix[DW-1 -: CW];
    g_o = pix[2*CW-1 -: CW];
    b_o = pix[CW-1:0];
`endif
  end

`ifndef JTFRAME_MIX_DIM_EN
  logic unused_pause;
  assign unused_pause = bus.pause;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_act  <= PRIO_ID;
      lvbl_last <= 1'b0;
      for (int i = 0; i < LAYERS; i++) s1_pxl[i] <= '0;
      s1_opq    <= '0;
      s1_hb     <= 1'b0;
      s1_vb     <= 1'b0;
      s2_addr   <= '0;
      s2_bd     <= 1'b0;
      s2_hb     <= 1'b0;
      s2_vb     <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      hb_q      <= 1'b0;
      vb_q      <= 1'b0;
    end else if (bus.cen) begin
      lvbl_last <= bus.lvbl;
      // A write landing on the vblank edge waits for the next frame.
      if (!bus.lvbl && lvbl_last) prio_act <= prio_pend;
      for (int i = 0; i < LAYERS; i++) begin
        s1_pxl[i] <= bus.layer_pxl[i*PXLW +: PXLW];
        s1_opq[i] <= bus.layer_en[i] && (bus.layer_pxl[i*PXLW +: 4] != 4'hF);
      end
      s1_hb   <= bus.lhbl;
      s1_vb   <= bus.lvbl;
      s2_addr <= {win, pxl_ext[win]};
      s2_bd   <= !found;
      s2_hb   <= s1_hb;
      s2_vb   <= s1_vb;
      hb_q    <= s2_hb;
      vb_q    <= s2_vb;
      if (!s2_hb || !s2_vb) begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end else begin
        red_q   <= r_o;
        green_q <= g_o;
        blue_q  <= b_o;
      end
    end
  end

  assign bus.red      = red_q;
  assign bus.green    = green_q;
  assign bus.blue     = blue_q;
  assign bus.lhbl_dly = hb_q;
  assign bus.lvbl_dly = vb_q;
endmodule
